fwd_operand_mux_reg: RTL and testbench
======================================

Name: fwd_operand_mux_reg

Overview:
Parametrised N-way operand-forwarding selector with a registered output stage for the pipelined RISC-V core. It picks one of N_SRC operand sources (regfile, EX/MEM, MEM/WB, WB, immediate, ...) by binary select and registers the result into the next stage. It supports valid, stall and flush control. It detects out-of-range selects and has a configurable fallback policy. Each out-of-range event is flagged for one cycle and counted in a saturating counter.

Parameters:
WIDTH, 32, operand width in bits (>=1)
N_SRC, 5, number of source inputs (>=2)
SEL_W, max(1,$clog2(N_SRC)), select width; derived, not overridden
OOR_MODE, 0, out-of-range policy: 0 = output zero, 1 = hold previous out_data
CNT_W, 8, width of the out-of-range event counter

Ports:
clk  input  1  rising-edge clock
reset  input  1  synchronous, active-high reset
sel  input  SEL_W  source index; in_bus slice sel is chosen
in_bus  input  N_SRC*WIDTH  flattened sources; source k = in_bus[k*WIDTH +: WIDTH]
in_valid  input  1  the operand on sel/in_bus is meaningful this cycle
stall  input  1  hold the output register (pipeline stall)
flush  input  1  squash the output register (branch/exception flush)
out_data  output  WIDTH  registered selected operand
out_valid  output  1  out_data is valid
out_sel_err  output  1  one-cycle pulse: the last accepted operand had sel >= N_SRC
err_count  output  CNT_W  saturating count of accepted out-of-range selects

Behaviour:
- Clock and reset: one clock (clk). Reset is synchronous and active-high (reset). All state updates only on the rising edge of clk.
- Reset values: out_data=0, out_valid=0, out_sel_err=0, err_count=0.
- Latency: 1 cycle. Inputs sampled at edge t appear on the outputs after edge t.
- Per-edge priority: reset > flush > stall > load.
- Flush: out_valid<=0, out_data<=0, out_sel_err<=0. err_count holds. A flush in the same cycle as an out-of-range select does not count the event.
- Stall (no flush): out_data, out_valid, out_sel_err and err_count all hold, so the out_sel_err pulse stretches across a stall. in_valid/sel are ignored; the upstream stage is responsible for holding them.
- Load (no reset/flush/stall): out_valid<=in_valid.
- Load with in_valid=1 and sel<N_SRC: out_data<=source[sel], out_sel_err<=0.
- Load with in_valid=1 and sel>=N_SRC: out_data<=0 when OOR_MODE=0, or holds its current value when OOR_MODE=1. out_sel_err<=1. err_count<=err_count+1, saturating at 2^CNT_W-1 with no wrap.
- Load with in_valid=0: out_data holds, out_sel_err<=0, no count, and sel is not checked.
- When N_SRC is a power of two, out-of-range is impossible: out_sel_err stays 0 and err_count stays 0.
- Combinational path: sel/in_bus to the next-state logic only. There is no combinational input-to-output path.
- Reset asserted mid-stream (with or without stall/flush) clears everything on that edge. The first load can occur on the edge after reset deasserts.

Decomposition:
- Shared package fwd_pkg: OOR_ZERO=0 and OOR_HOLD=1 constants, a sel_width(n) function returning max(1,clog2(n)), and the forwarding source index constants (SRC_RF=0, SRC_EXMEM=1, SRC_MEMWB=2, SRC_WB=3, SRC_IMM=4).
- Sub-module nway_mux (WIDTH, N_SRC): pure combinational index into in_bus. It outputs the selected word plus an oor flag, and drives zero when out of range. fwd_operand_mux_reg instantiates it and adds the register, control and counter logic.

Test Plan:
1. Reset, then in_valid=1, sel=2, source2=32'hDEADBEEF -> one cycle later out_data=DEADBEEF, out_valid=1, out_sel_err=0.
2. Sweep sel=0..4 on consecutive cycles with source k=k+32'h100 -> out_data follows 0x100..0x104 with 1-cycle lag; then a stall for 3 cycles while sel changes -> out_data holds 0x104 for those 3 cycles.
3. OOR_MODE=0, sel=6, in_valid=1 -> out_data=0, out_sel_err pulses for 1 cycle, err_count=1. With OOR_MODE=1 and previous out_data=0x55 -> out_data stays 0x55.
4. CNT_W=2, five consecutive out-of-range loads -> err_count reads 1,2,3,3,3 (saturates, no wrap).
5. flush and stall together with in_valid=1, sel=7 -> out_valid=0, out_data=0, out_sel_err=0, err_count unchanged.
6. N_SRC=4, WIDTH=8: random sel/in_bus for 1000 cycles compared against a model -> exact match; out_sel_err is never 1 and err_count stays 0.

Source files
------------

// File: rtl/fwd_pkg.sv
`default_nettype none
// ============================================================================
//  Package     : fwd_pkg
//  Description : Shared constants and helpers for the operand-forwarding
//                selector: out-of-range policy codes, select-width helper
//                and the canonical forwarding source indices.
//  Revision    : 1.0 - initial release
// ============================================================================
package fwd_pkg;

    // Out-of-range select policy codes
    localparam int OOR_ZERO = 0;   // out-of-range load drives zero
    localparam int OOR_HOLD = 1;   // out-of-range load keeps previous operand

    // Canonical forwarding source indices
    localparam int SRC_RF    = 0;
    localparam int SRC_EXMEM = 1;
    localparam int SRC_MEMWB = 2;
    localparam int SRC_WB    = 3;
    localparam int SRC_IMM   = 4;

    // Select width for n sources; a 2-way mux still needs one select bit
    function automatic int sel_width(input int n);
        int w;
        w = $clog2(n);
        if (w < 1) begin
            w = 1;
        end
        return w;
    endfunction

endpackage : fwd_pkg
`default_nettype wire

// File: rtl/nway_mux.sv
`default_nettype none
// ============================================================================
//  Module      : nway_mux
//  Description : Combinational N-way word selector over a flattened bus.
//                Flags selects that address a non-existent source and
//                drives zero in that case.
//  Revision    : 1.0 - initial release
// ============================================================================
module nway_mux
    import fwd_pkg::*;
#(
    parameter  int WIDTH = 32,
    parameter  int N_SRC = 5,
    localparam int SEL_W = sel_width(N_SRC)
) (
    input  logic [SEL_W-1:0]       sel,
    input  logic [N_SRC*WIDTH-1:0] in_bus,
    output logic [WIDTH-1:0]       data,
    output logic                   oor
);

    logic w_oor;

    // A power-of-two source count covers every select code, so no range check
    generate
        if (N_SRC == (1 << SEL_W)) begin : g_full_range
            assign w_oor = 1'b0;
        end else begin : g_partial_range
            localparam logic [SEL_W:0] c_n_src = N_SRC[SEL_W:0];
            assign w_oor = ({1'b0, sel} >= c_n_src);
        end
    endgenerate

    // Select the addressed word; nothing matches when out of range, leaving zero
    always_comb begin
        data = '0;
        for (int k = 0; k < N_SRC; k++) begin
            if (sel == k[SEL_W-1:0]) begin
                data = in_bus[k*WIDTH +: WIDTH];
            end
        end
    end

    assign oor = w_oor;

endmodule : nway_mux
`default_nettype wire

// File: rtl/fwd_operand_mux_reg.sv
`default_nettype none
// ============================================================================
//  Module      : fwd_operand_mux_reg
//  Description : Operand-forwarding selector with a registered output stage.
//                Supports valid/stall/flush, out-of-range select detection
//                with a zero-or-hold fallback, a one-cycle error flag and a
//                saturating error counter.
//  Revision    : 1.0 - initial release
// ============================================================================
module fwd_operand_mux_reg
    import fwd_pkg::*;
#(
    parameter  int WIDTH    = 32,
    parameter  int N_SRC    = 5,
    parameter  int OOR_MODE = 0,
    parameter  int CNT_W    = 8,
    localparam int SEL_W    = sel_width(N_SRC)
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [SEL_W-1:0]       sel,
    input  logic [N_SRC*WIDTH-1:0] in_bus,
    input  logic                   in_valid,
    input  logic                   stall,
    input  logic                   flush,
    output logic [WIDTH-1:0]       out_data,
    output logic                   out_valid,
    output logic                   out_sel_err,
    output logic [CNT_W-1:0]       err_count
);

    logic [WIDTH-1:0] w_mux_data;
    logic             w_oor;
    logic [WIDTH-1:0] w_load_data;

    logic [WIDTH-1:0] r_out_data;
    logic             r_out_valid;
    logic             r_sel_err;
    logic [CNT_W-1:0] r_err_count;

    nway_mux #(
        .WIDTH (WIDTH),
        .N_SRC (N_SRC)
    ) u_mux (
        .sel    (sel),
        .in_bus (in_bus),
        .data   (w_mux_data),
        .oor    (w_oor)
    );

    // Operand to load: the mux already yields zero when out of range, so only
    // the hold policy needs to substitute the current register contents
    always_comb begin
        w_load_data = w_mux_data;
        if (w_oor && (OOR_MODE == OOR_HOLD)) begin
            w_load_data = r_out_data;
        end
    end

    // Output stage: reset > flush > stall > load; invalid loads do not check sel
    always_ff @(posedge clk) begin
        if (reset) begin
            r_out_data  <= '0;
            r_out_valid <= 1'b0;
            r_sel_err   <= 1'b0;
            r_err_count <= '0;
        end else if (flush) begin
            r_out_data  <= '0;
            r_out_valid <= 1'b0;
            r_sel_err   <= 1'b0;
        end else if (!stall) begin
            r_out_valid <= in_valid;
            if (in_valid) begin
                r_out_data <= w_load_data;
                r_sel_err  <= w_oor;
                if (w_oor && (r_err_count != {CNT_W{1'b1}})) begin
                    r_err_count <= r_err_count + 1'b1;
                end
            end else begin
                r_sel_err <= 1'b0;
            end
        end
    end

    assign out_data    = r_out_data;
    assign out_valid   = r_out_valid;
    assign out_sel_err = r_sel_err;
    assign err_count   = r_err_count;

endmodule : fwd_operand_mux_reg
`default_nettype wire

// File: tb/tb_fwd_operand_mux_reg.sv
`default_nettype none
// ============================================================================
//  Module      : tb_fwd_operand_mux_reg
//  Description : Scoreboard bench for fwd_operand_mux_reg. Three instances:
//                A (5 src, zero policy, 2-bit counter), B (5 src, hold
//                policy, 8-bit counter), C (4 src, 8-bit operands).
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_fwd_operand_mux_reg;

    typedef struct {
        logic [31:0] data;
        bit          valid;
        bit          err;
        int          cnt;
    } exp_t;

    logic         clk = 1'b0;
    logic         reset, in_valid, stall, flush;
    logic [2:0]   sel_ab;
    logic [1:0]   sel_c;
    logic [159:0] bus_ab;
    logic [31:0]  bus_c;

    logic [31:0]  a_data, b_data;
    logic [7:0]   c_data;
    logic         a_valid, b_valid, c_valid;
    logic         a_err, b_err, c_err;
    logic [1:0]   a_cnt;
    logic [7:0]   b_cnt, c_cnt;

    logic [31:0]  src_ab [5];
    exp_t         ma, mb, mc;
    exp_t         qa[$], qb[$], qc[$];
    int           n_checks = 0;
    int           n_fail   = 0;

    always #5 clk = ~clk;

    fwd_operand_mux_reg #(.WIDTH(32), .N_SRC(5), .OOR_MODE(0), .CNT_W(2)) dut_a (
        .clk(clk), .reset(reset), .sel(sel_ab), .in_bus(bus_ab),
        .in_valid(in_valid), .stall(stall), .flush(flush),
        .out_data(a_data), .out_valid(a_valid), .out_sel_err(a_err), .err_count(a_cnt));

    fwd_operand_mux_reg #(.WIDTH(32), .N_SRC(5), .OOR_MODE(1), .CNT_W(8)) dut_b (
        .clk(clk), .reset(reset), .sel(sel_ab), .in_bus(bus_ab),
        .in_valid(in_valid), .stall(stall), .flush(flush),
        .out_data(b_data), .out_valid(b_valid), .out_sel_err(b_err), .err_count(b_cnt));

    fwd_operand_mux_reg #(.WIDTH(8), .N_SRC(4), .OOR_MODE(0), .CNT_W(8)) dut_c (
        .clk(clk), .reset(reset), .sel(sel_c), .in_bus(bus_c),
        .in_valid(in_valid), .stall(stall), .flush(flush),
        .out_data(c_data), .out_valid(c_valid), .out_sel_err(c_err), .err_count(c_cnt));

    // Behavioural next-output rule for one pipeline register
    function automatic exp_t model_next(input exp_t cur, input bit r, input bit v,
                                        input bit s, input bit f, input int sel,
                                        input int nsrc, input bit hold, input int cmax,
                                        input logic [31:0] src);
        exp_t n;
        n = cur;
        if (r) begin
            n.data = 0; n.valid = 0; n.err = 0; n.cnt = 0;
        end else if (f) begin
            n.data = 0; n.valid = 0; n.err = 0;
        end else if (!s) begin
            n.valid = v;
            if (!v) begin
                n.err = 0;
            end else if (sel < nsrc) begin
                n.data = src;
                n.err  = 0;
            end else begin
                if (!hold) n.data = 0;
                n.err = 1;
                if (n.cnt < cmax) n.cnt = n.cnt + 1;
            end
        end
        return n;
    endfunction

    // One cycle of stimulus; expected outputs after the coming edge are queued
    task automatic step(input bit r, input bit v, input bit s, input bit f, input int sa);
        int          sc;
        logic [31:0] srcv;
        @(negedge clk);
        sc       = int'($urandom_range(0, 3));
        reset    = r;
        in_valid = v;
        stall    = s;
        flush    = f;
        sel_ab   = sa[2:0];
        sel_c    = sc[1:0];
        bus_c    = $urandom;
        for (int k = 0; k < 5; k++) bus_ab[k*32 +: 32] = src_ab[k];
        srcv = 32'd0;
        if (sa < 5) srcv = src_ab[sa];
        ma = model_next(ma, r, v, s, f, sa, 5, 1'b0, 3, srcv);
        mb = model_next(mb, r, v, s, f, sa, 5, 1'b1, 255, srcv);
        mc = model_next(mc, r, v, s, f, sc, 4, 1'b0, 255, {24'd0, bus_c[sc*8 +: 8]});
        qa.push_back(ma);
        qb.push_back(mb);
        qc.push_back(mc);
        @(posedge clk);
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: after each edge, pop the expected outputs and compare
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (qa.size() > 0) begin
                e = qa.pop_front();
                chk("a_data", a_data, e.data);
                chk("a_valid", 32'(a_valid), 32'(e.valid));
                chk("a_err", 32'(a_err), 32'(e.err));
                chk("a_cnt", 32'(a_cnt), e.cnt);
            end
            if (qb.size() > 0) begin
                e = qb.pop_front();
                chk("b_data", b_data, e.data);
                chk("b_valid", 32'(b_valid), 32'(e.valid));
                chk("b_err", 32'(b_err), 32'(e.err));
                chk("b_cnt", 32'(b_cnt), e.cnt);
            end
            if (qc.size() > 0) begin
                e = qc.pop_front();
                chk("c_data", 32'(c_data), e.data);
                chk("c_valid", 32'(c_valid), 32'(e.valid));
                chk("c_err", 32'(c_err), 32'(e.err));
                chk("c_cnt", 32'(c_cnt), e.cnt);
            end
        end
    end

    initial begin
        ma = '{data: 0, valid: 0, err: 0, cnt: 0};
        mb = ma;
        mc = ma;
        for (int k = 0; k < 5; k++) src_ab[k] = 32'd0;
        reset = 1'b1; in_valid = 1'b0; stall = 1'b0; flush = 1'b0;
        sel_ab = 3'd0; sel_c = 2'd0; bus_ab = '0; bus_c = '0;

        // Reset, then a single valid load from source 2
        step(1, 0, 0, 0, 0);
        step(1, 1, 0, 0, 0);
        src_ab[2] = 32'hDEADBEEF;
        step(0, 1, 0, 0, 2);

        // Sweep all in-range sources, then stall while sel changes
        for (int k = 0; k < 5; k++) src_ab[k] = 32'h100 + k;
        for (int k = 0; k < 5; k++) step(0, 1, 0, 0, k);
        for (int k = 0; k < 3; k++) step(0, 1, 1, 0, k);

        // Out-of-range with a known previous operand, then recovery
        src_ab[0] = 32'h55;
        step(0, 1, 0, 0, 0);
        step(0, 1, 0, 0, 6);
        step(0, 1, 0, 0, 1);
        // Out-of-range pulse stretched by a stall, then invalid load
        step(0, 1, 0, 0, 7);
        step(0, 1, 1, 0, 2);
        step(0, 0, 0, 0, 5);

        // Counter saturation: five consecutive out-of-range loads after reset
        step(1, 0, 0, 0, 0);
        for (int k = 0; k < 5; k++) step(0, 1, 0, 0, 5 + (k % 3));

        // Flush with stall and an out-of-range select; invalid out-of-range
        step(0, 1, 0, 0, 3);
        step(0, 1, 1, 1, 7);
        step(0, 0, 0, 0, 6);
        // Reset during a stall
        step(0, 1, 0, 0, 4);
        step(1, 1, 1, 0, 6);
        step(0, 1, 0, 0, 1);

        // Randomized traffic
        for (int i = 0; i < 1000; i++) begin
            for (int k = 0; k < 5; k++) src_ab[k] = $urandom;
            step(($urandom_range(0, 63) == 0), ($urandom_range(0, 3) != 0),
                 ($urandom_range(0, 7) == 0), ($urandom_range(0, 15) == 0),
                 int'($urandom_range(0, 7)));
        end

        step(0, 0, 0, 0, 0);
        repeat (2) @(posedge clk);
        #2;
        chk("scoreboard_drained", 32'(qa.size() + qb.size() + qc.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule : tb_fwd_operand_mux_reg
`default_nettype wire
